// File: rtl/fire_scheduler_if.sv
// Handshake/status bundle between a run controller and the fire scheduler.
// The controller side (master) drives the run controls and the excitation vector.
interface fire_scheduler_if #(
    parameter int NT = 8,
    parameter int FW = 4
);
    logic          start;
    logic          stop;
    logic          mode;
    logic [15:0]   seed;
    logic [31:0]   max_steps;
    logic [NT-1:0] excited;
    logic [FW-1:0] fire;
    logic          busy;
    logic          done;
    logic          deadlock;
    logic [31:0]   step_count;
    logic [FW-1:0] last_fired;

    modport master (
        output start, stop, mode, seed, max_steps, excited,
        input  fire, busy, done, deadlock, step_count, last_fired
    );

    modport slave (
        input  start, stop, mode, seed, max_steps, excited,
        output fire, busy, done, deadlock, step_count, last_fired
    );
endinterface

// File: rtl/fire_scheduler.sv
// Picks one excited transition per step (round-robin or LFSR-random), drives its
// index on fire for one cycle, then idles while the modelled circuit settles.
module fire_scheduler #(
    parameter int NT     = 8,
    parameter int FW     = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    fire_scheduler_if.slave  bus
);
    localparam logic [FW-1:0] IDLE_CODE = '1;
    localparam logic [15:0]   LFSR_DEF  = 16'hACE1;

    typedef enum logic [1:0] {S_IDLE, S_PICK, S_FIRE, S_SETTLE} state_t;

    state_t        state;
    logic [FW-1:0] ptr;
    logic [15:0]   lfsr;
    logic [31:0]   settle_cnt;
    logic [FW-1:0] rr_first;
    logic [FW-1:0] rnd_first;
    logic [FW-1:0] sel;

    // First set bit of exc scanning first, first+1, ... modulo NT.
    function automatic logic [FW-1:0] scan_from(input logic [FW-1:0] first,
                                                input logic [NT-1:0] exc);
        logic [FW-1:0] res;
        logic          found;
        int            idx;
        res   = IDLE_CODE;
        found = 1'b0;
        for (int k = 0; k < NT; k++) begin
            idx = (int'(first) + k) % NT;
            if (!found && exc[idx]) begin
                res   = FW'(idx);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_comb begin
        rr_first  = FW'((int'(ptr) + 1) % NT);
        rnd_first = FW'(int'(lfsr) % NT);
        sel       = bus.mode ? scan_from(rnd_first, bus.excited)
                             : scan_from(rr_first, bus.excited);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            ptr            <= FW'(NT - 1);
            lfsr           <= LFSR_DEF;
            settle_cnt     <= '0;
            bus.fire       <= IDLE_CODE;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.deadlock   <= 1'b0;
            bus.step_count <= '0;
            bus.last_fired <= IDLE_CODE;
        end else begin
            case (state)
                S_IDLE: begin
                    // stop has priority over a simultaneous start
                    if (bus.start && !bus.stop) begin
                        state          <= S_PICK;
                        bus.busy       <= 1'b1;
                        bus.done       <= 1'b0;
                        bus.deadlock   <= 1'b0;
                        bus.step_count <= '0;
                        ptr            <= FW'(NT - 1);
                        lfsr           <= (bus.seed == 16'h0000) ? LFSR_DEF : bus.seed;
                    end
                end
                S_PICK: begin
                    if (bus.stop) begin
                        state    <= S_IDLE;
                        bus.busy <= 1'b0;
                    end else if (bus.max_steps != 32'd0 && bus.step_count == bus.max_steps) begin
                        state    <= S_IDLE;
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                    end else if (bus.excited == '0) begin
                        state        <= S_IDLE;
                        bus.deadlock <= 1'b1;
                        bus.busy     <= 1'b0;
                    end else begin
                        state          <= S_FIRE;
                        bus.fire       <= sel;
                        bus.last_fired <= sel;
                        bus.step_count <= sat_inc(bus.step_count);
                        ptr            <= sel;
                        lfsr           <= lfsr_next(lfsr);
                    end
                end
                S_FIRE: begin
                    bus.fire   <= IDLE_CODE;
                    settle_cnt <= '0;
                    if (bus.stop) begin
                        state    <= S_IDLE;
                        bus.busy <= 1'b0;
                    end else if (SETTLE == 0) begin
                        state <= S_PICK;
                    end else begin
                        state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (bus.stop) begin
                        state    <= S_IDLE;
                        bus.busy <= 1'b0;
                    end else if (settle_cnt == 32'(SETTLE - 1)) begin
                        state <= S_PICK;
                    end else begin
                        settle_cnt <= settle_cnt + 32'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fire_scheduler.sv
// Directed bench for fire_scheduler with NT=8, FW=4, SETTLE=1.
module tb_fire_scheduler;
    logic clk;
    logic reset;
    int   checks;
    int   failures;
    logic [3:0] cap [0:99];
    int   cap_n;
    logic [3:0] ref_seq [0:99];

    fire_scheduler_if #(.NT(8), .FW(4)) bus ();

    fire_scheduler #(.NT(8), .FW(4), .SETTLE(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++; if (bus.fire !== 4'hF) begin failures++; $display("FAIL reset_fire got=%h exp=f", bus.fire); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0 || bus.deadlock !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", bus.done, bus.deadlock); end
        checks++; if (bus.step_count !== 32'd0) begin failures++; $display("FAIL reset_steps got=%0d exp=0", bus.step_count); end
        checks++; if (bus.last_fired !== 4'hF) begin failures++; $display("FAIL reset_last got=%h exp=f", bus.last_fired); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_seq [0:3];
        exp_seq = '{4'd0, 4'd2, 4'd0, 4'd2};
        bus.mode = 1'b0; bus.max_steps = 32'd0; bus.excited = 8'b0000_0101;
        pulse_start();
        checks++; if (bus.busy !== 1'b1 || bus.fire !== 4'hF) begin failures++; $display("FAIL rr_pick busy=%b fire=%h exp busy=1 fire=f", bus.busy, bus.fire); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.fire !== exp_seq[i]) begin failures++; $display("FAIL rr_fire[%0d] got=%h exp=%h", i, bus.fire, exp_seq[i]); end
            checks++; if (bus.step_count !== 32'(i + 1)) begin failures++; $display("FAIL rr_steps[%0d] got=%0d exp=%0d", i, bus.step_count, i + 1); end
            tick();
            checks++; if (bus.fire !== 4'hF) begin failures++; $display("FAIL rr_settle_idle[%0d] got=%h exp=f", i, bus.fire); end
            tick();
            checks++; if (bus.fire !== 4'hF) begin failures++; $display("FAIL rr_pick_idle[%0d] got=%h exp=f", i, bus.fire); end
        end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.fire !== 4'hF) begin failures++; $display("FAIL rr_stop busy=%b done=%b fire=%h exp 0 0 f", bus.busy, bus.done, bus.fire); end
    endtask

    task automatic test_budget();
        logic [3:0] exp_seq [0:2];
        exp_seq = '{4'd0, 4'd1, 4'd2};
        bus.mode = 1'b0; bus.max_steps = 32'd3; bus.excited = 8'hFF;
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.fire !== exp_seq[i]) begin failures++; $display("FAIL budget_fire[%0d] got=%h exp=%h", i, bus.fire, exp_seq[i]); end
            tick();
            tick();
        end
        tick();
        checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin failures++; $display("FAIL budget_done done=%b busy=%b exp 1 0", bus.done, bus.busy); end
        checks++; if (bus.step_count !== 32'd3) begin failures++; $display("FAIL budget_steps got=%0d exp=3", bus.step_count); end
        checks++; if (bus.last_fired !== 4'd2) begin failures++; $display("FAIL budget_last got=%h exp=2", bus.last_fired); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.fire !== 4'hF || bus.done !== 1'b1) begin failures++; $display("FAIL budget_after[%0d] fire=%h done=%b exp f 1", i, bus.fire, bus.done); end
        end
    endtask

    task automatic test_deadlock();
        bus.mode = 1'b0; bus.max_steps = 32'd0; bus.excited = 8'h00;
        pulse_start();
        checks++; if (bus.deadlock !== 1'b0 || bus.done !== 1'b0) begin failures++; $display("FAIL dl_clear_on_start deadlock=%b done=%b exp 0 0", bus.deadlock, bus.done); end
        tick();
        checks++; if (bus.deadlock !== 1'b1 || bus.busy !== 1'b0) begin failures++; $display("FAIL dl_flag deadlock=%b busy=%b exp 1 0", bus.deadlock, bus.busy); end
        checks++; if (bus.step_count !== 32'd0 || bus.fire !== 4'hF) begin failures++; $display("FAIL dl_nofire steps=%0d fire=%h exp 0 f", bus.step_count, bus.fire); end
        tick();
        checks++; if (bus.deadlock !== 1'b1) begin failures++; $display("FAIL dl_sticky got=%b exp=1", bus.deadlock); end
        bus.excited = 8'h01;
        pulse_start();
        checks++; if (bus.deadlock !== 1'b0 || bus.busy !== 1'b1) begin failures++; $display("FAIL dl_restart deadlock=%b busy=%b exp 0 1", bus.deadlock, bus.busy); end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
    endtask

    task automatic test_stop_in_fire();
        bus.mode = 1'b0; bus.max_steps = 32'd0; bus.excited = 8'b0000_1000;
        pulse_start();
        tick();
        bus.stop = 1'b1;
        checks++; if (bus.fire !== 4'd3) begin failures++; $display("FAIL stop_fire_completes got=%h exp=3", bus.fire); end
        tick();
        bus.stop = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.fire !== 4'hF) begin failures++; $display("FAIL stop_idle busy=%b fire=%h exp 0 f", bus.busy, bus.fire); end
        for (int i = 0; i < 4; i++) tick();
        checks++; if (bus.fire !== 4'hF || bus.step_count !== 32'd1 || bus.done !== 1'b0) begin failures++; $display("FAIL stop_quiet fire=%h steps=%0d done=%b exp f 1 0", bus.fire, bus.step_count, bus.done); end
    endtask

    task automatic run_capture(input logic [15:0] sd, input int n);
        bus.mode = 1'b1; bus.seed = sd; bus.max_steps = 32'(n); bus.excited = 8'b1001_0000;
        pulse_start();
        cap_n = 0;
        for (int c = 0; c < n * 3 + 20 && bus.done !== 1'b1; c++) begin
            tick();
            if (bus.fire !== 4'hF) begin
                if (cap_n < 100) cap[cap_n] = bus.fire;
                cap_n++;
            end
        end
    endtask

    task automatic test_lfsr();
        int bad;
        run_capture(16'h1234, 100);
        checks++; if (cap_n != 100 || bus.done !== 1'b1) begin failures++; $display("FAIL lfsr_count got=%0d done=%b exp 100 1", cap_n, bus.done); end
        checks++; if (cap[0] !== 4'd4 || cap[1] !== 4'd4 || cap[2] !== 4'd7 || cap[3] !== 4'd7) begin failures++; $display("FAIL lfsr_first4 got=%h%h%h%h exp=4477", cap[0], cap[1], cap[2], cap[3]); end
        bad = 0;
        for (int i = 0; i < 100; i++) if (cap[i] !== 4'd4 && cap[i] !== 4'd7) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL lfsr_only_excited bad=%0d exp=0", bad); end
        for (int i = 0; i < 100; i++) ref_seq[i] = cap[i];
        run_capture(16'h1234, 100);
        bad = 0;
        for (int i = 0; i < 100; i++) if (cap[i] !== ref_seq[i]) bad++;
        checks++; if (bad != 0 || cap_n != 100) begin failures++; $display("FAIL lfsr_repeat diffs=%0d n=%0d exp 0 100", bad, cap_n); end
        run_capture(16'hACE1, 20);
        for (int i = 0; i < 20; i++) ref_seq[i] = cap[i];
        run_capture(16'h0000, 20);
        bad = 0;
        for (int i = 0; i < 20; i++) if (cap[i] !== ref_seq[i]) bad++;
        checks++; if (bad != 0 || cap_n != 20) begin failures++; $display("FAIL lfsr_seed0 diffs=%0d n=%0d exp 0 20", bad, cap_n); end
    endtask

    task automatic test_reset_mid();
        bus.mode = 1'b0; bus.max_steps = 32'd0; bus.excited = 8'hFF;
        pulse_start();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (bus.fire !== 4'hF || bus.step_count !== 32'd0) begin failures++; $display("FAIL midreset_fire_steps fire=%h steps=%0d exp f 0", bus.fire, bus.step_count); end
        checks++; if (bus.busy !== 1'b0 || bus.last_fired !== 4'hF || bus.done !== 1'b0 || bus.deadlock !== 1'b0) begin failures++; $display("FAIL midreset_status busy=%b last=%h done=%b dl=%b exp 0 f 0 0", bus.busy, bus.last_fired, bus.done, bus.deadlock); end
        for (int i = 0; i < 3; i++) tick();
        checks++; if (bus.fire !== 4'hF || bus.busy !== 1'b0) begin failures++; $display("FAIL midreset_stays_idle fire=%h busy=%b exp f 0", bus.fire, bus.busy); end
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1;
        bus.start = 1'b0; bus.stop = 1'b0; bus.mode = 1'b0; bus.seed = 16'h0000;
        bus.max_steps = 32'd0; bus.excited = '0;
        test_reset();
        test_round_robin();
        test_budget();
        test_deadlock();
        test_stop_in_fire();
        test_lfsr();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fire_scheduler.md
Name: fire_scheduler

Overview:
- Generates the `fire` transition index for the synchronous circuit model. That model updates one input/gate flop per clock, namely the one whose index equals `fire`.
- Each step, it picks one currently excited transition (round-robin or LFSR-random), drives it for exactly one cycle, then holds an idle code while the circuit settles.
- It also counts steps, stops at a step budget, and flags deadlock when no transition is excited.

Parameters:
- NT, 8, number of transitions (inputs + stateful gates/latches); indices 0..NT-1.
- FW, 4, width of `fire`; must satisfy NT <= 2^FW - 1.
- SETTLE, 1, idle cycles inserted after each fire before the next pick (>=0).
- Idle code IDLE = all-ones (2^FW - 1). It never matches any transition index.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  pulse; begin a run (ignored while busy)
- stop  in  1  abort the run; returns to IDLE at the next edge
- mode  in  1  0 = round-robin, 1 = LFSR random
- seed  in  16  LFSR seed, loaded on start; 0 is replaced by 16'hACE1
- max_steps  in  32  step budget; 0 = unbounded
- excited  in  NT  bit i = transition i is currently enabled
- fire  out  FW  registered transition index, or IDLE
- busy  out  1  run in progress
- done  out  1  sticky; budget reached
- deadlock  out  1  sticky; PICK found excited==0
- step_count  out  32  fires issued in this run
- last_fired  out  FW  most recent fired index (IDLE before the first fire)

Behaviour:
- Reset values: fire=IDLE, busy=0, done=0, deadlock=0, step_count=0, last_fired=IDLE, ptr=NT-1, lfsr=16'hACE1, state=IDLE. Reset overrides everything, including mid-run.
- States: IDLE, PICK, FIRE, SETTLE.
- IDLE:
  - start=1 -> PICK.
  - On that edge: busy<=1, done<=0, deadlock<=0, step_count<=0, ptr<=NT-1, lfsr<=seed (or ACE1 if seed is 0).
- PICK (one cycle), checks in priority order:
  - stop -> IDLE.
  - max_steps!=0 and step_count==max_steps -> IDLE with done<=1, busy<=0.
  - excited==0 -> IDLE with deadlock<=1, busy<=0.
  - Otherwise: fire<=sel, last_fired<=sel, step_count<=step_count+1, ptr<=sel, -> FIRE.
- FIRE (exactly one cycle; fire shows sel):
  - fire<=IDLE.
  - If SETTLE==0 -> PICK, else -> SETTLE.
- SETTLE:
  - Counts SETTLE cycles, then -> PICK.
  - stop -> IDLE.
- Round-robin selection: sel = first set bit of `excited` scanning ptr+1, ptr+2, ... modulo NT (wraps).
- LFSR selection:
  - Galois LFSR, taps x^16+x^14+x^13+x^11+1; advances once per PICK that fires.
  - Start index r = lfsr % NT.
  - sel = first set bit scanning r, r+1, ... modulo NT.
- Only excited transitions are ever fired; fire is IDLE in every cycle except the one FIRE cycle.
- Timing:
  - start sampled at edge k -> PICK during cycle k+1 -> fire valid during cycle k+2.
  - Step period = 2 + SETTLE cycles.
- `excited` is sampled only in PICK; changes during FIRE/SETTLE are ignored.
- stop:
  - During FIRE: the current fire still completes its single cycle; then the FSM enters IDLE instead of SETTLE/PICK.
  - done and deadlock are not set by stop.
- step_count saturates at 2^32-1 (unbounded mode).
- start while busy is ignored. start and stop together in IDLE: stop wins (remain in IDLE).
- done and deadlock clear only on reset or the next accepted start.

Test Plan:
- RR, NT=8, SETTLE=1, excited=8'b0000_0101, start, max_steps=0 -> fire sequence 0,2,0,2 with period 3 cycles; IDLE (4'hF) between fires; step_count increments per fire.
- RR, max_steps=3, excited=8'hFF -> fires 0,1,2; then done=1, busy=0, step_count=3, last_fired=2, fire=IDLE from then on.
- excited=0 at start -> deadlock=1 two cycles after start, no fire ever issued, step_count=0; next start clears deadlock.
- LFSR mode, seed=16'h1234, excited=8'b1001_0000, 100 steps -> only 4 and 7 fired; rerun with same seed gives an identical sequence; seed=0 matches seed=ACE1.
- stop asserted during FIRE -> that single fire completes, busy=0 next cycle, no further fires, done=0.
- reset asserted mid-SETTLE -> next cycle all outputs at reset values (fire=4'hF, step_count=0).
